// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, imem ready-handshake and IF/ID register; 1 instr/cycle on zero-wait memory.
// Stalls park an accepted word in a one-entry hold buffer; redirects in flight are drained in KILL.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        if_id_flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, KILL} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] hold_buf;
  logic [31:0] kill_addr;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        advance;

  logic        pc_load_target;
  logic        pc_inc;
  logic        ifid_load;
  logic        ifid_from_buf;
  logic        ifid_bubble;
  logic        buf_capture;
  logic        kill_capture;

  assign advance  = pc_write & if_id_write;
  assign target   = branch_target & 32'hFFFF_FFFC;
  assign pc_plus4 = pc + 32'd4;
  assign pc_out   = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (branch_taken) begin
          state_nxt = imem_ready ? REQ : KILL;
        end else if (imem_ready && (!advance || if_id_flush)) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          state_nxt = REQ;
        end else if (!if_id_flush && advance) begin
          state_nxt = REQ;
        end
      end
      KILL: begin
        if (imem_ready) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req       = 1'b0;
    imem_addr      = pc;
    pc_load_target = 1'b0;
    pc_inc         = 1'b0;
    ifid_load      = 1'b0;
    ifid_from_buf  = 1'b0;
    ifid_bubble    = 1'b0;
    buf_capture    = 1'b0;
    kill_capture   = 1'b0;
    case (state)
      REQ: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          pc_load_target = 1'b1;
          ifid_bubble    = 1'b1;
          kill_capture   = !imem_ready;
        end else if (imem_ready && advance && !if_id_flush) begin
          ifid_load = 1'b1;
          pc_inc    = 1'b1;
        end else if (imem_ready) begin
          buf_capture = 1'b1;
          ifid_bubble = if_id_flush;
        end else begin
          ifid_bubble = if_id_write | if_id_flush;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_load_target = 1'b1;
          ifid_bubble    = 1'b1;
        end else if (if_id_flush) begin
          ifid_bubble = 1'b1;
        end else if (advance) begin
          ifid_load     = 1'b1;
          ifid_from_buf = 1'b1;
          pc_inc        = 1'b1;
        end
      end
      KILL: begin
        // pc already points at the redirect; the bus keeps the old address until it completes
        imem_req       = 1'b1;
        imem_addr      = kill_addr;
        pc_load_target = branch_taken;
        ifid_bubble    = if_id_write | if_id_flush;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc                <= RESET_PC;
      hold_buf          <= NOP;
      kill_addr         <= 32'h0;
      if_id_instruction <= NOP;
      if_id_pc_plus4    <= 32'h0;
      if_id_valid       <= 1'b0;
    end else begin
      if (pc_load_target) begin
        pc <= target;
      end else if (pc_inc) begin
        pc <= pc_plus4;
      end
      if (buf_capture) begin
        hold_buf <= imem_rdata;
      end
      if (kill_capture) begin
        kill_addr <= pc;
      end
      if (ifid_bubble) begin
        if_id_instruction <= NOP;
        if_id_valid       <= 1'b0;
      end else if (ifid_load) begin
        if_id_instruction <= ifid_from_buf ? hold_buf : imem_rdata;
        if_id_pc_plus4    <= pc_plus4;
        if_id_valid       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, mid-request reset, and a random run
// checked against an instruction-stream model (expected next fetch address).
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, if_id_write, if_id_flush, branch_taken, imem_ready;
  logic [31:0] branch_target;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, imem_rdata, pc_out, if_id_instruction, if_id_pc_plus4;
  logic        w_imem_req, w_if_id_valid;
  logic [31:0] w_imem_addr, w_imem_rdata, w_pc_out, w_if_id_instruction, w_if_id_pc_plus4;

  always #5 clk = ~clk;

  // Instruction memory: word at address a is a | A000_0000
  assign imem_rdata   = imem_addr | 32'hA000_0000;
  assign w_imem_rdata = w_imem_addr | 32'hA000_0000;

  if_fetch_stage u_dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .pc_out(pc_out), .if_id_instruction(if_id_instruction),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .imem_ready(imem_ready), .pc_out(w_pc_out), .if_id_instruction(w_if_id_instruction),
    .if_id_pc_plus4(w_if_id_pc_plus4), .if_id_valid(w_if_id_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        pw, iw, fl, br;
    logic [31:0] tgt;
    logic        rdy;
    logic        req;
    logic [31:0] addr, pc;
    logic        vld;
    logic [31:0] ins, p4;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(input logic pw, iw, fl, br, input logic [31:0] tgt, input logic rdy,
                              input logic req, input logic [31:0] addr, pc, input logic vld,
                              input logic [31:0] ins, p4);
    vec_t v;
    v.pw = pw; v.iw = iw; v.fl = fl; v.br = br; v.tgt = tgt; v.rdy = rdy;
    v.req = req; v.addr = addr; v.pc = pc; v.vld = vld; v.ins = ins; v.p4 = p4;
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"}, {31'h0, imem_req}, 32'h0);
    chk({tag, "_pc"}, pc_out, 32'h0);
    chk({tag, "_vld"}, {31'h0, if_id_valid}, 32'h0);
    chk({tag, "_ins"}, if_id_instruction, 32'h0);
    chk({tag, "_p4"}, if_id_pc_plus4, 32'h0);
  endtask

  task automatic set_inputs(input logic pw, iw, fl, br, input logic [31:0] tgt, input logic rdy);
    pc_write = pw; if_id_write = iw; if_id_flush = fl;
    branch_taken = br; branch_target = tgt; imem_ready = rdy;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_next, prev_addr, a;
    logic        prev_req;
    logic        r_pw, r_iw, r_fl, r_br, r_rdy;
    logic [31:0] r_tgt;
    int          delivered;

    //            pw iw fl br tgt           rdy | req addr          pc            vld ins           p4
    vecs[0]  = mk(1, 1, 0, 0, 32'h0,        1,    1,  32'h0,        32'h0,        0,  32'h0,        32'h0);
    vecs[1]  = mk(1, 1, 0, 0, 32'h0,        1,    1,  32'h4,        32'h4,        1,  32'hA000_0000, 32'h4);
    vecs[2]  = mk(1, 1, 0, 0, 32'h0,        1,    1,  32'h8,        32'h8,        1,  32'hA000_0004, 32'h8);
    vecs[3]  = mk(1, 1, 0, 0, 32'h0,        0,    1,  32'h8,        32'h8,        0,  32'h0,        32'h0);
    vecs[4]  = mk(1, 1, 0, 0, 32'h0,        0,    1,  32'h8,        32'h8,        0,  32'h0,        32'h0);
    vecs[5]  = mk(1, 1, 0, 0, 32'h0,        1,    1,  32'hC,        32'hC,        1,  32'hA000_0008, 32'hC);
    vecs[6]  = mk(1, 1, 0, 0, 32'h0,        0,    1,  32'hC,        32'hC,        0,  32'h0,        32'h0);
    vecs[7]  = mk(1, 1, 0, 0, 32'h0,        0,    1,  32'hC,        32'hC,        0,  32'h0,        32'h0);
    vecs[8]  = mk(1, 1, 0, 0, 32'h0,        1,    1,  32'h10,       32'h10,       1,  32'hA000_000C, 32'h10);
    vecs[9]  = mk(0, 0, 0, 0, 32'h0,        1,    0,  32'h10,       32'h10,       1,  32'hA000_000C, 32'h10);
    vecs[10] = mk(0, 0, 0, 0, 32'h0,        1,    0,  32'h10,       32'h10,       1,  32'hA000_000C, 32'h10);
    vecs[11] = mk(0, 0, 0, 0, 32'h0,        1,    0,  32'h10,       32'h10,       1,  32'hA000_000C, 32'h10);
    vecs[12] = mk(1, 1, 0, 0, 32'h0,        1,    1,  32'h14,       32'h14,       1,  32'hA000_0010, 32'h14);
    vecs[13] = mk(1, 1, 0, 0, 32'h0,        1,    1,  32'h18,       32'h18,       1,  32'hA000_0014, 32'h18);
    vecs[14] = mk(1, 1, 0, 0, 32'h0,        1,    1,  32'h1C,       32'h1C,       1,  32'hA000_0018, 32'h1C);
    vecs[15] = mk(1, 1, 0, 0, 32'h0,        1,    1,  32'h20,       32'h20,       1,  32'hA000_001C, 32'h20);
    vecs[16] = mk(1, 1, 0, 0, 32'h0,        0,    1,  32'h20,       32'h20,       0,  32'h0,        32'h0);
    vecs[17] = mk(1, 1, 0, 1, 32'h103,      0,    1,  32'h20,       32'h100,      0,  32'h0,        32'h0);
    vecs[18] = mk(1, 1, 0, 0, 32'h0,        0,    1,  32'h20,       32'h100,      0,  32'h0,        32'h0);
    vecs[19] = mk(1, 1, 0, 0, 32'h0,        1,    1,  32'h100,      32'h100,      0,  32'h0,        32'h0);
    vecs[20] = mk(1, 1, 0, 0, 32'h0,        1,    1,  32'h104,      32'h104,      1,  32'hA000_0100, 32'h104);
    vecs[21] = mk(1, 1, 0, 1, 32'h40,       1,    1,  32'h40,       32'h40,       0,  32'h0,        32'h0);
    vecs[22] = mk(1, 1, 1, 0, 32'h0,        1,    0,  32'h40,       32'h40,       0,  32'h0,        32'h0);
    vecs[23] = mk(1, 1, 0, 0, 32'h0,        1,    1,  32'h44,       32'h44,       1,  32'hA000_0040, 32'h44);
    vecs[24] = mk(1, 1, 0, 0, 32'h0,        1,    1,  32'h48,       32'h48,       1,  32'hA000_0044, 32'h48);
    vecs[25] = mk(0, 0, 0, 0, 32'h0,        1,    0,  32'h48,       32'h48,       1,  32'hA000_0044, 32'h48);
    vecs[26] = mk(0, 0, 0, 1, 32'h200,      1,    1,  32'h200,      32'h200,      0,  32'h0,        32'h0);
    vecs[27] = mk(1, 1, 0, 0, 32'h0,        1,    1,  32'h204,      32'h204,      1,  32'hA000_0200, 32'h204);
    vecs[28] = mk(1, 1, 0, 1, 32'hFFFF_FFFC, 1,   1,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0,        32'h0);
    vecs[29] = mk(1, 1, 0, 0, 32'h0,        1,    1,  32'h0,        32'h0,        1,  32'hFFFF_FFFC, 32'h0);

    // Reset held for two cycles
    rst = 1'b1;
    set_inputs(1, 1, 0, 0, 32'h0, 1);
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    chk("rst_wrap_pc", w_pc_out, 32'hFFFF_FFFC);
    chk("rst_wrap_req", {31'h0, w_imem_req}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      set_inputs(vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].br, vecs[i].tgt, vecs[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].req});
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("v%0d_pc", i), pc_out, vecs[i].pc);
      chk($sformatf("v%0d_vld", i), {31'h0, if_id_valid}, {31'h0, vecs[i].vld});
      chk($sformatf("v%0d_ins", i), if_id_instruction, vecs[i].ins);
      if (vecs[i].vld) chk($sformatf("v%0d_p4", i), if_id_pc_plus4, vecs[i].p4);
      if (i == 1) begin
        chk("wrap_p4", w_if_id_pc_plus4, 32'h0);
        chk("wrap_ins", w_if_id_instruction, 32'hFFFF_FFFC);
        chk("wrap_vld", {31'h0, w_if_id_valid}, 32'h1);
        chk("wrap_addr", w_imem_addr, 32'h0);
      end
    end

    // Reset while a request is outstanding takes effect without a clock edge
    set_inputs(1, 1, 0, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    chk("mid_req_before", {31'h0, imem_req}, 32'h1);
    rst = 1'b1;
    #1;
    check_reset_values("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    imem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_req_after", {31'h0, imem_req}, 32'h1);
    chk("mid_rst_addr_after", imem_addr, 32'h0);

    // Random run: every delivered word must follow the expected fetch stream
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_next  = 32'h0;
    delivered = 0;
    prev_req  = imem_req;
    prev_addr = imem_addr;
    for (int n = 0; n < 3000; n++) begin
      r_pw  = ($urandom_range(0, 4) != 0);
      r_iw  = ($urandom_range(0, 4) != 0);
      r_fl  = ($urandom_range(0, 9) == 0);
      r_br  = ($urandom_range(0, 11) == 0);
      r_tgt = $urandom & 32'h0000_FFFF;
      r_rdy = ($urandom_range(0, 4) < 3);
      set_inputs(r_pw, r_iw, r_fl, r_br, r_tgt, r_rdy);
      @(posedge clk);
      #1;
      if (r_br) begin
        exp_next = {r_tgt[31:2], 2'b00};
        chk("rnd_branch_pc", pc_out, exp_next);
        chk("rnd_branch_vld", {31'h0, if_id_valid}, 32'h0);
      end else if (r_fl) begin
        chk("rnd_flush_vld", {31'h0, if_id_valid}, 32'h0);
      end else if (r_pw && r_iw && if_id_valid) begin
        a = if_id_pc_plus4 - 32'd4;
        chk("rnd_order", a, exp_next);
        chk("rnd_word", if_id_instruction, exp_next | 32'hA000_0000);
        exp_next = exp_next + 32'd4;
        chk("rnd_pc_after_load", pc_out, exp_next);
        delivered++;
      end
      if (prev_req && !r_rdy) chk("rnd_addr_stable", imem_addr, prev_addr);
      prev_req  = imem_req;
      prev_addr = imem_addr;
    end
    total++;
    if (delivered < 200) begin
      bad++;
      $display("FAIL rnd_throughput: got %0d delivered expected at least 200", delivered);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
